// File: rtl/mult_div_if.sv
// Handshake/bus bundle between the issue logic (master) and the multiply/divide unit (slave).
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             MthiWrite;
    logic             MtloWrite;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, OperandA, OperandB, MthiWrite, MtloWrite,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, MthiWrite, MtloWrite,
        output Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Magnitudes are processed unsigned; signs are restored in the FINISH cycle.
//
//   state  | meaning
//   Idle   | waiting; accepts Start or MTHI/MTLO writes
//   Calc   | one shift-add / restoring-divide step per cycle, ITER cycles
//   Finish | sign correction, HI/LO write, Done pulse follows
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input logic       Clk,
    input logic       Reset,
    mult_div_if.slave Bus
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {Idle, Calc, Finish} stateT;

    stateT              state, nextState;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opB;
    logic [WIDTH-1:0]   aRaw;
    logic               isDiv, bZero, negRes, negRem;
    logic [WIDTH-1:0]   hiReg, loReg;
    logic               doneReg;

    logic               signedOp, aNeg, bNeg;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     remShift;
    logic               divFits;
    logic [2*WIDTH-1:0] iterNext;
    logic [2*WIDTH-1:0] prodFixed;
    logic [WIDTH-1:0]   hiRes, loRes;

    assign signedOp = ~Bus.Op[0];
    assign aNeg     = signedOp & Bus.OperandA[WIDTH-1];
    assign bNeg     = signedOp & Bus.OperandB[WIDTH-1];
    assign absA     = aNeg ? -Bus.OperandA : Bus.OperandA;
    assign absB     = bNeg ? -Bus.OperandB : Bus.OperandB;

    // acc holds {upper product, remaining multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
        remShift = acc[2*WIDTH-1:WIDTH-1];
        divFits  = remShift >= {1'b0, opB};
        iterNext = {mulSum, acc[WIDTH-1:1]};
        if (isDiv) begin
            iterNext = {divFits ? (remShift[WIDTH-1:0] - opB) : remShift[WIDTH-1:0],
                        acc[WIDTH-2:0], divFits};
        end
    end

    always_comb begin
        prodFixed = negRes ? -acc : acc;
        hiRes     = prodFixed[2*WIDTH-1:WIDTH];
        loRes     = prodFixed[WIDTH-1:0];
        if (isDiv) begin
            if (bZero) begin
                hiRes = aRaw;
                loRes = '1;
            end else begin
                hiRes = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                loRes = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= Idle;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            Idle:    if (Bus.Start) nextState = Calc;
            Calc:    if (count == LAST) nextState = Finish;
            Finish:  nextState = Idle;
            default: nextState = Idle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count   <= '0;
            acc     <= '0;
            opB     <= '0;
            aRaw    <= '0;
            isDiv   <= 1'b0;
            bZero   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                Idle: begin
                    if (Bus.Start) begin
                        isDiv  <= Bus.Op[1];
                        bZero  <= (Bus.OperandB == '0);
                        negRes <= aNeg ^ bNeg;
                        negRem <= aNeg;
                        aRaw   <= Bus.OperandA;
                        opB    <= absB;
                        acc    <= {{WIDTH{1'b0}}, absA};
                        count  <= '0;
                    end else begin
                        // Start has priority; MT writes only land on a quiet cycle
                        if (Bus.MthiWrite) hiReg <= Bus.OperandA;
                        if (Bus.MtloWrite) loReg <= Bus.OperandA;
                    end
                end
                Calc: begin
                    acc   <= iterNext;
                    count <= count + 1'b1;
                end
                Finish: begin
                    hiReg   <= hiRes;
                    loReg   <= loRes;
                    doneReg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Bus.Busy = (state != Idle);
    assign Bus.Done = doneReg;
    assign Bus.Hi   = hiReg;
    assign Bus.Lo   = loReg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised scoreboard bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    logic Clk;
    logic Reset;

    mult_div_if #(.WIDTH(32)) Bus ();

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Bus   (Bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } expT;

    expT         scoreQ[$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] hiM, loM;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sbv, q, r, sp;
        longint unsigned up;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = sp;
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {hi, lo} = up;
            end
            2'd2: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    sa  = longint'($signed(a));
                    sbv = longint'($signed(b));
                    q   = sa / sbv;
                    r   = sa % sbv;
                    lo  = q[31:0];
                    hi  = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // mode 0: plain, 1: inject Start+MTHI while busy, 2: MTHI together with Start
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [31:0] eh, el;
        refModel(op, a, b, eh, el);
        Bus.Start     = 1'b1;
        Bus.Op        = op;
        Bus.OperandA  = a;
        Bus.OperandB  = b;
        Bus.MthiWrite = (mode == 2);
        Bus.MtloWrite = (mode == 2);
        scoreQ.push_back('{eh, el, $sformatf("op%0d %h,%h", op, a, b)});
        hiM = eh;
        loM = el;
        for (int c = 0; c <= 32; c++) begin
            @(negedge Clk);
            Bus.Start     = 1'b0;
            Bus.MthiWrite = 1'b0;
            Bus.MtloWrite = 1'b0;
            Bus.Op        = 2'($urandom_range(0, 3));
            Bus.OperandA  = $urandom;
            Bus.OperandB  = $urandom;
            if (mode == 1 && c == 5) begin
                Bus.Start     = 1'b1;
                Bus.Op        = 2'd3;
                Bus.OperandA  = 32'h0000_1234;
                Bus.OperandB  = 32'd3;
                Bus.MthiWrite = 1'b1;
            end
            check($sformatf("busy_c%0d", c), {31'd0, Bus.Busy}, 32'd1);
        end
        @(negedge Clk);
        check("done_pulse", {31'd0, Bus.Done}, 32'd1);
        check("busy_at_done", {31'd0, Bus.Busy}, 32'd0);
    endtask

    initial begin : monitor
        expT e;
        forever begin
            @(negedge Clk);
            if (Bus.Done === 1'b1) begin
                if (scoreQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_done: got Done=1 expected no pending result at %0t", $time);
                end else begin
                    e = scoreQ.pop_front();
                    check({e.name, " hi"}, Bus.Hi, e.hi);
                    check({e.name, " lo"}, Bus.Lo, e.lo);
                end
            end
        end
    end

    initial begin : stimulus
        int doneSeen;
        int r;
        logic [1:0]  op;
        logic [31:0] a, b;
        Reset         = 1'b1;
        Bus.Start     = 1'b0;
        Bus.Op        = 2'd0;
        Bus.OperandA  = 32'hDEAD_BEEF;
        Bus.OperandB  = 32'h1234_5678;
        Bus.MthiWrite = 1'b1;
        Bus.MtloWrite = 1'b1;
        hiM = '0;
        loM = '0;
        repeat (2) @(negedge Clk);
        check("rst_busy", {31'd0, Bus.Busy}, 32'd0);
        check("rst_done", {31'd0, Bus.Done}, 32'd0);
        check("rst_hi", Bus.Hi, 32'd0);
        check("rst_lo", Bus.Lo, 32'd0);
        Reset         = 1'b0;
        Bus.MthiWrite = 1'b0;
        Bus.MtloWrite = 1'b0;
        @(negedge Clk);

        runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        runOp(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        runOp(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        runOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        runOp(2'd3, 32'h0000_0064, 32'h0000_0000, 0);
        runOp(2'd2, 32'h0000_0064, 32'h0000_0000, 0);
        runOp(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1);

        Bus.MthiWrite = 1'b1;
        Bus.OperandA  = 32'h0000_1234;
        @(negedge Clk);
        Bus.MthiWrite = 1'b0;
        hiM = 32'h0000_1234;
        check("mthi_hi", Bus.Hi, hiM);
        check("mthi_lo_hold", Bus.Lo, loM);
        Bus.MtloWrite = 1'b1;
        Bus.OperandA  = 32'h0000_CAFE;
        @(negedge Clk);
        Bus.MtloWrite = 1'b0;
        loM = 32'h0000_CAFE;
        check("mtlo_lo", Bus.Lo, loM);
        check("mtlo_hi_hold", Bus.Hi, hiM);
        Bus.MthiWrite = 1'b1;
        Bus.MtloWrite = 1'b1;
        Bus.OperandA  = 32'h55AA_33CC;
        @(negedge Clk);
        Bus.MthiWrite = 1'b0;
        Bus.MtloWrite = 1'b0;
        Bus.OperandA  = 32'h0;
        hiM = 32'h55AA_33CC;
        loM = 32'h55AA_33CC;
        check("mtboth_hi", Bus.Hi, hiM);
        check("mtboth_lo", Bus.Lo, loM);
        repeat (3) @(negedge Clk);
        check("idle_hold_hi", Bus.Hi, hiM);
        check("idle_hold_lo", Bus.Lo, loM);

        runOp(2'd3, 32'd1000, 32'd7, 2);

        // Reset landing at edge k+10 of a DIV
        Bus.Start    = 1'b1;
        Bus.Op       = 2'd2;
        Bus.OperandA = 32'd100;
        Bus.OperandB = 32'd7;
        @(negedge Clk);
        Bus.Start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        hiM = '0;
        loM = '0;
        check("rst_mid_busy", {31'd0, Bus.Busy}, 32'd0);
        check("rst_mid_done", {31'd0, Bus.Done}, 32'd0);
        check("rst_mid_hi", Bus.Hi, 32'd0);
        check("rst_mid_lo", Bus.Lo, 32'd0);
        doneSeen = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Bus.Done === 1'b1) doneSeen++;
        end
        check("rst_no_done", 32'(doneSeen), 32'd0);
        runOp(2'd2, 32'd100, 32'd7, 0);

        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = 32'd1;
            else if (r == 3) b = {28'd0, 4'($urandom)};
            runOp(op, a, b, $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) @(negedge Clk);
        end

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", 32'(scoreQ.size()), 32'd0);
        check("final_hi", Bus.Hi, hiM);
        check("final_lo", Bus.Lo, loM);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
